instr_encoder_writer: RTL and testbench
=======================================

// Module: instr_encoder_writer
// PURPOSE
//  Write-side counterpart of the main control decoder. Accepts decoded instruction
//  fields (kind, rs, rt, rd, funct, imm) over a valid/ready handshake. Encodes each
//  into a 32-bit MIPS word using the decoder's opcode set (R=000000, addi=001000,
//  slti=001010, beq=000100) and writes it sequentially into instruction memory.
//  Used to load test programs into the single-cycle CPU before it runs.
// PARAMETERS
//  ADDR_W     8       word-address width; capacity = 2**ADDR_W instructions
//  BASE_ADDR  32'h0   byte address of the first written word (word aligned)
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       asynchronous, active-low reset
//  start_i      in   1       begin/restart a load; sampled in IDLE and DONE only
//  kind_i       in   2       00=R-format 01=addi 10=slti 11=beq
//  rs_i         in   5       rs field
//  rt_i         in   5       rt field
//  rd_i         in   5       rd field (R-format only)
//  funct_i      in   6       funct field (R-format only)
//  imm_i        in   16      immediate / branch offset (I-format only)
//  last_i       in   1       current beat is the final instruction
//  in_valid_i   in   1       field beat valid
//  in_ready_o   out  1       block accepts a beat this cycle
//  imem_we_o    out  1       instruction-memory write strobe, one cycle per word
//  imem_addr_o  out  32      byte address = BASE_ADDR + 4*ptr
//  imem_data_o  out  32      encoded instruction word
//  count_o      out  ADDR_W+1  words written since last start
//  busy_o       out  1       state is LOAD or WRITE
//  done_o       out  1       load finished; held until next start_i
//  full_o       out  1       load ended because memory is full
// BEHAVIOUR
//  Reset (rst_i=0, asynchronous): state=IDLE, ptr=0, count_o=0. All outputs are 0,
//   including imem_we_o, which drops immediately. A write in flight is abandoned;
//   no partial write occurs.
//  Encoding (combinational from inputs, registered on accept):
//   R:    {6'b000000, rs, rt, rd, 5'b00000, funct}
//   addi: {6'b001000, rs, rt, imm}   slti: {6'b001010, rs, rt, imm}
//   beq:  {6'b000100, rs, rt, imm}   (imm is a signed word offset, passed unchanged)
//  FSM states: IDLE, LOAD, WRITE, DONE.
//   IDLE:  in_ready_o=0. If start_i: ptr=0, count=0 -> LOAD.
//   LOAD:  in_ready_o=1. On in_valid_i&&in_ready_o: latch the word into imem_data_o,
//          latch last_i into last_q, set imem_addr_o=BASE_ADDR+{ptr,2'b00} -> WRITE.
//          Without valid: stay in LOAD.
//   WRITE: imem_we_o=1 for exactly this cycle; in_ready_o=0; ptr++, count_o++.
//          If last_q or ptr==2**ADDR_W-1: -> DONE (full_o=1 iff the ptr condition
//          holds and last_q=0). Otherwise -> LOAD.
//   DONE:  done_o=1; in_ready_o=0. start_i clears done_o, full_o, ptr, count -> LOAD.
//  Throughput: 1 word per 2 cycles. Latency from accept to we = 1 cycle.
//  imem_addr_o and imem_data_o hold their last values outside WRITE.
//  start_i in LOAD or WRITE is ignored; in_valid_i outside LOAD is ignored.
//  When last_i and the full condition coincide: done_o=1, full_o=0.
//  count_o reaches 2**ADDR_W exactly when full; no wrap and no overwrite past the
//   last slot.
// TESTING
//  1. start; addi rs=0 rt=8 imm=5 last=1 -> one we pulse, addr 0x0, data 0x20080005,
//     done_o=1, count_o=1.
//  2. R rs=8 rt=9 rd=10 funct=0x20, then slti rs=8 rt=9 imm=10, then beq rs=8 rt=9
//     imm=0xFFFE last -> data 0x01095020, 0x2909000A, 0x1109FFFE at 0x0, 0x4, 0x8.
//  3. ADDR_W=2, stream 6 beats without last -> 4 writes (0x0..0xC), full_o=1,
//     in_ready_o=0 after the 4th write, count_o=4.
//  4. Toggle in_valid_i randomly and pulse start_i during LOAD/WRITE -> no beat is
//     lost or duplicated, start_i has no effect, we spacing >= 2 cycles.
//  5. Assert rst_i low in the WRITE cycle -> imem_we_o=0 asynchronously; after
//     release, IDLE with all outputs 0; a new start writes again from BASE_ADDR.
//  6. BASE_ADDR=32'h100, restart from DONE -> addresses restart at 0x100, done_o and
//     count_o cleared.

Source files
------------

// File: rtl/instr_encoder_writer.sv
// Packs decoded instruction fields into 32-bit MIPS words and streams them into
// instruction memory at consecutive word addresses. One word is written every two cycles.
module instr_encoder_writer #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic              last_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              imem_we_o,
    output logic [31:0]       imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              full_o
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              last_q;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic              we_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              full_q;
    logic [31:0]       enc_d;
    logic              ptr_at_max;

    always_comb begin
        enc_d = '0;
        unique case (kind_i)
            2'b00: enc_d = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            2'b01: enc_d = {6'b001000, rs_i, rt_i, imm_i};
            2'b10: enc_d = {6'b001010, rs_i, rt_i, imm_i};
            2'b11: enc_d = {6'b000100, rs_i, rt_i, imm_i};
        endcase
    end

    assign ptr_at_max = (ptr_q == PTR_MAX);

    // All outputs are registers so an async reset drops them (including the write strobe) at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        ptr_q   <= '0;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        full_q  <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        data_q  <= enc_d;
                        last_q  <= last_i;
                        addr_q  <= BASE_ADDR + (32'(ptr_q) << 2);
                        we_q    <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    we_q    <= 1'b0;
                    ptr_q   <= ptr_q + 1'b1;
                    count_q <= count_q + (ADDR_W+1)'(1);
                    // Last slot just written: stop here rather than wrap onto slot 0.
                    if (last_q || ptr_at_max) begin
                        done_q  <= 1'b1;
                        full_q  <= ptr_at_max && !last_q;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= LOAD;
                    end
                end
            endcase
        end
    end

    assign in_ready_o  = ready_q;
    assign imem_we_o   = we_q;
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign count_o     = count_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign full_o      = full_q;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Scoreboard bench for instr_encoder_writer: dut 0 uses defaults, dut 1 has a
// 4-word memory at byte base 0x100 to exercise the full and relocation paths.
module tb_instr_encoder_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn[2], start[2], last[2], vld[2];
    logic [1:0]  kind[2];
    logic [4:0]  rs[2], rt[2], rd[2];
    logic [5:0]  funct[2];
    logic [15:0] imm[2];
    logic        rdy[2], we[2], busy[2], done[2], full[2];
    logic [31:0] addr[2], data[2];
    logic [8:0]  cnt0;
    logic [2:0]  cnt1;

    instr_encoder_writer dut0 (
        .clk_i(clk), .rst_i(rstn[0]), .start_i(start[0]), .kind_i(kind[0]),
        .rs_i(rs[0]), .rt_i(rt[0]), .rd_i(rd[0]), .funct_i(funct[0]), .imm_i(imm[0]),
        .last_i(last[0]), .in_valid_i(vld[0]), .in_ready_o(rdy[0]), .imem_we_o(we[0]),
        .imem_addr_o(addr[0]), .imem_data_o(data[0]), .count_o(cnt0), .busy_o(busy[0]),
        .done_o(done[0]), .full_o(full[0])
    );

    instr_encoder_writer #(.ADDR_W(2), .BASE_ADDR(32'h100)) dut1 (
        .clk_i(clk), .rst_i(rstn[1]), .start_i(start[1]), .kind_i(kind[1]),
        .rs_i(rs[1]), .rt_i(rt[1]), .rd_i(rd[1]), .funct_i(funct[1]), .imm_i(imm[1]),
        .last_i(last[1]), .in_valid_i(vld[1]), .in_ready_o(rdy[1]), .imem_we_o(we[1]),
        .imem_addr_o(addr[1]), .imem_data_o(data[1]), .count_o(cnt1), .busy_o(busy[1]),
        .done_o(done[1]), .full_o(full[1])
    );

    typedef struct packed {
        logic [1:0]  k;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  f;
        logic [15:0] imm;
        logic [31:0] w;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    vec_t V[8];
    exp_t q0[$], q1[$];
    int   tests = 0, fails = 0;
    int   cyc = 0;
    int   last_we[2] = '{-10, -10};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt(int d);
        return (d == 0) ? 32'(cnt0) : 32'(cnt1);
    endfunction

    // Monitor: every write strobe pops one expectation and is checked for spacing.
    task automatic mon(int d);
        exp_t e;
        bit   have;
        if (we[d]) begin
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            tests++;
            if (!have) begin
                fails++;
                $display("FAIL dut%0d unexpected write: addr %h data %h", d, addr[d], data[d]);
            end else if (addr[d] !== e.a || data[d] !== e.d) begin
                fails++;
                $display("FAIL dut%0d write: got addr %h data %h want addr %h data %h",
                         d, addr[d], data[d], e.a, e.d);
            end
            tests++;
            if (cyc - last_we[d] < 2) begin
                fails++;
                $display("FAIL dut%0d we spacing: got %0d want >=2", d, cyc - last_we[d]);
            end
            last_we[d] = cyc;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic do_start(int d);
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        chk("start ready", 32'(rdy[d]), 32'd1);
        chk("start done clr", {29'd0, done[d], full[d], busy[d]}, 32'b001);
        chk("start count clr", cnt(d), 32'd0);
    endtask

    // Offers beat vi; in noisy mode adds random idle gaps, stray start pulses in
    // LOAD/WRITE, and keeps valid high through the WRITE cycle.
    task automatic send(int d, int vi, bit lst, logic [31:0] ea, bit push, bit noise);
        exp_t e;
        bit   ok;
        int   gap;
        gap = noise ? int'($urandom_range(0, 3)) : 0;
        repeat (gap) begin
            @(posedge clk); #1;
            start[d] = 1'($urandom_range(0, 1));
        end
        kind[d] = V[vi].k; rs[d] = V[vi].rs; rt[d] = V[vi].rt; rd[d] = V[vi].rd;
        funct[d] = V[vi].f; imm[d] = V[vi].imm; last[d] = lst; vld[d] = 1'b1;
        if (push) begin
            e.a = ea; e.d = V[vi].w;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rdy[d]) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL dut%0d accept timeout: got no ready want ready", d);
        end
        if (noise) begin
            start[d] = 1'b1;
            @(posedge clk); #1;
            start[d] = 1'b0;
        end
        vld[d] = 1'b0;
        last[d] = 1'b0;
    endtask

    task automatic wait_done(int d);
        for (int i = 0; i < 10 && !done[d]; i++) begin
            @(posedge clk); #1;
        end
        chk("done", 32'(done[d]), 32'd1);
    endtask

    initial begin
        V[0] = '{k:2'd1, rs:5'd0,  rt:5'd8,  rd:5'h1F, f:6'h3F, imm:16'h0005, w:32'h20080005};
        V[1] = '{k:2'd0, rs:5'd8,  rt:5'd9,  rd:5'd10, f:6'h20, imm:16'hFFFF, w:32'h01095020};
        V[2] = '{k:2'd2, rs:5'd8,  rt:5'd9,  rd:5'd3,  f:6'h01, imm:16'h000A, w:32'h2909000A};
        V[3] = '{k:2'd3, rs:5'd8,  rt:5'd9,  rd:5'd0,  f:6'h00, imm:16'hFFFE, w:32'h1109FFFE};
        V[4] = '{k:2'd1, rs:5'd1,  rt:5'd2,  rd:5'd7,  f:6'h15, imm:16'h7FFF, w:32'h20227FFF};
        V[5] = '{k:2'd0, rs:5'd31, rt:5'd31, rd:5'd31, f:6'h3F, imm:16'h1234, w:32'h03FFF83F};
        V[6] = '{k:2'd3, rs:5'd3,  rt:5'd4,  rd:5'd9,  f:6'h2A, imm:16'h8000, w:32'h10648000};
        V[7] = '{k:2'd2, rs:5'd31, rt:5'd0,  rd:5'd1,  f:6'h10, imm:16'h1234, w:32'h2BE01234};
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; start[d] = 1'b0; last[d] = 1'b0; vld[d] = 1'b0;
            kind[d] = '0; rs[d] = '0; rt[d] = '0; rd[d] = '0; funct[d] = '0; imm[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset flags", {27'd0, rdy[d], we[d], busy[d], done[d], full[d]}, 32'd0);
            chk("reset count", cnt(d), 32'd0);
            chk("reset addr", addr[d], 32'd0);
            chk("reset data", data[d], 32'd0);
        end
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        @(posedge clk); #1;
        chk("idle ready", 32'(rdy[0]), 32'd0);

        // single addi with last
        do_start(0);
        send(0, 0, 1'b1, 32'h0, 1'b1, 1'b0);
        wait_done(0);
        chk("t1 count", cnt(0), 32'd1);
        chk("t1 full", 32'(full[0]), 32'd0);
        chk("t1 ready", 32'(rdy[0]), 32'd0);

        // R, slti, beq from DONE
        do_start(0);
        send(0, 1, 1'b0, 32'h0, 1'b1, 1'b0);
        send(0, 2, 1'b0, 32'h4, 1'b1, 1'b0);
        send(0, 3, 1'b1, 32'h8, 1'b1, 1'b0);
        wait_done(0);
        chk("t2 count", cnt(0), 32'd3);

        // noisy stream of all vectors
        do_start(0);
        for (int i = 0; i < 8; i++)
            send(0, i, (i == 7), 32'(4 * i), 1'b1, 1'b1);
        wait_done(0);
        chk("t4 count", cnt(0), 32'd8);
        chk("t4 full", 32'(full[0]), 32'd0);

        // async reset in the WRITE cycle
        do_start(0);
        send(0, 4, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t5 we in write", 32'(we[0]), 32'd1);
        #2 rstn[0] = 1'b0;
        #1;
        chk("t5 we async drop", 32'(we[0]), 32'd0);
        chk("t5 data cleared", data[0], 32'd0);
        @(posedge clk); #1;
        rstn[0] = 1'b1;
        @(posedge clk); #1;
        chk("t5 idle flags", {27'd0, rdy[0], we[0], busy[0], done[0], full[0]}, 32'd0);
        chk("t5 idle count", cnt(0), 32'd0);
        do_start(0);
        send(0, 5, 1'b1, 32'h0, 1'b1, 1'b0);
        wait_done(0);
        chk("t5 count", cnt(0), 32'd1);

        // fill a 4-word memory, extra beats refused
        do_start(1);
        for (int i = 0; i < 4; i++)
            send(1, i + 4, 1'b0, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
        vld[1] = 1'b1; kind[1] = 2'd1; imm[1] = 16'hDEAD;
        wait_done(1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("t3 ready after full", 32'(rdy[1]), 32'd0);
        end
        vld[1] = 1'b0;
        chk("t3 full", 32'(full[1]), 32'd1);
        chk("t3 count", cnt(1), 32'd4);

        // restart from DONE at base 0x100
        do_start(1);
        chk("t6 full clr", 32'(full[1]), 32'd0);
        send(1, 0, 1'b1, 32'h100, 1'b1, 1'b0);
        wait_done(1);
        chk("t6 count", cnt(1), 32'd1);

        // last coincides with last slot
        do_start(1);
        for (int i = 0; i < 4; i++)
            send(1, i, (i == 3), 32'h100 + 32'(4 * i), 1'b1, 1'b0);
        wait_done(1);
        chk("coincide full", 32'(full[1]), 32'd0);
        chk("coincide count", cnt(1), 32'd4);

        repeat (3) @(posedge clk);
        #1;
        chk("dut0 pending writes", 32'(q0.size()), 32'd0);
        chk("dut1 pending writes", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
